// File: rtl/reduction_array_pkg.sv
// Shared definitions for reduction_array: operator encoding and per-operator identity.
package reduction_array_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_OR  = 2'd0;
  localparam op_t OP_AND = 2'd1;
  localparam op_t OP_XOR = 2'd2;
  localparam op_t OP_MAX = 2'd3;

  // Widest element the identity helper can describe.
  localparam int MAX_WIDTH = 64;

  // Identity value for op at the given width (low bits); callers cast to their width.
  function automatic logic [MAX_WIDTH-1:0] op_identity(op_t op, int width);
    logic [MAX_WIDTH-1:0] ones;
    ones = '1;
    if (op == OP_AND) return ones >> (MAX_WIDTH - width);
    return '0;
  endfunction

endpackage

// File: rtl/reduction_array_reduce_level.sv
// One registered level of the reduction tree: folds adjacent operand pairs under the
// request's own op and forwards op, count and valid alongside the partial results.
module reduce_level
  import reduction_array_pkg::*;
#(
  parameter int PAIRS = 2,
  parameter int WIDTH = 8,
  parameter int CNTW  = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  input  op_t                      req_op,
  input  logic [CNTW-1:0]          req_count,
  input  logic [2*PAIRS*WIDTH-1:0] operands,
  output logic                     level_valid,
  output op_t                      level_op,
  output logic [CNTW-1:0]          level_count,
  output logic [PAIRS*WIDTH-1:0]   partials
);

  logic [PAIRS*WIDTH-1:0] combined;

  function automatic logic [WIDTH-1:0] combine(op_t o, logic [WIDTH-1:0] a, logic [WIDTH-1:0] b);
    case (o)
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return (a > b) ? a : b;
    endcase
  endfunction

  always_comb begin
    combined = '0;
    for (int p = 0; p < PAIRS; p++) begin
      combined[p*WIDTH +: WIDTH] = combine(req_op,
                                           operands[(2*p)*WIDTH +: WIDTH],
                                           operands[(2*p+1)*WIDTH +: WIDTH]);
    end
  end

  // Payload only moves with a request, so the last level naturally holds its result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_valid <= 1'b0;
      level_op    <= OP_OR;
      level_count <= '0;
      partials    <= '0;
    end else begin
      level_valid <= req_valid;
      if (req_valid) begin
        level_op    <= req_op;
        level_count <= req_count;
        partials    <= combined;
      end
    end
  end

endmodule

// File: rtl/reduction_array.sv
// Register array with per-element valid bits and a pipelined OR/AND/XOR/MAX reduction
// over the valid elements; one launch per cycle, results in launch order.
module reduction_array
  import reduction_array_pkg::*;
#(
  parameter int  ELEMENTS = 4,
  parameter int  WIDTH    = 8,
  localparam int IDXW     = $clog2(ELEMENTS),
  localparam int LEVELS   = IDXW
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      enable,
  input  logic                      remove,
  input  logic [IDXW-1:0]           index,
  input  logic [WIDTH-1:0]          element,
  output logic [ELEMENTS*WIDTH-1:0] array,
  output logic [ELEMENTS-1:0]       valid_mask,
  input  logic                      start,
  input  op_t                       op,
  output logic [WIDTH-1:0]          result,
  output logic [IDXW:0]             result_count,
  output logic                      result_valid
);

  localparam int SLOTS = 1 << LEVELS;
  localparam int CNTW  = IDXW + 1;
  localparam logic [CNTW-1:0] ELEM_LIM = CNTW'(ELEMENTS);

  // Handshake: start is accepted on every cycle (no ready, no backpressure); each
  // accepted request produces exactly one result_valid pulse LEVELS+1 edges later.

  logic [WIDTH-1:0]       data [ELEMENTS];
  logic [ELEMENTS-1:0]    valid_q;
  logic                   in_range;
  logic [WIDTH-1:0]       ident;
  logic [SLOTS*WIDTH-1:0] masked;
  logic [CNTW-1:0]        pop;

  logic                   snap_valid;
  op_t                    snap_op;
  logic [CNTW-1:0]        snap_count;
  logic [SLOTS*WIDTH-1:0] snap_data;

  logic                   stage_valid [LEVELS+1];
  op_t                    stage_op    [LEVELS+1];
  logic [CNTW-1:0]        stage_count [LEVELS+1];

  assign valid_mask = valid_q;
  assign in_range   = {1'b0, index} < ELEM_LIM;

  for (genvar i = 0; i < ELEMENTS; i++) begin : flat
    assign array[i*WIDTH +: WIDTH] = data[i];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ELEMENTS; i++) data[i] <= '0;
      valid_q <= '0;
    end else if (clear) begin
      for (int i = 0; i < ELEMENTS; i++) data[i] <= '0;
      valid_q <= '0;
    end else if (enable && in_range) begin
      if (remove) begin
        valid_q[index] <= 1'b0;
      end else begin
        data[index]    <= element;
        valid_q[index] <= 1'b1;
      end
    end
  end

  // Invalid elements and padding slots become the operator identity so they never
  // influence the result.
  assign ident = WIDTH'(op_identity(op, WIDTH));

  for (genvar s = 0; s < SLOTS; s++) begin : slot
    if (s < ELEMENTS) begin : real_slot
      assign masked[s*WIDTH +: WIDTH] = valid_q[s] ? data[s] : ident;
    end else begin : pad_slot
      assign masked[s*WIDTH +: WIDTH] = ident;
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < ELEMENTS; i++) pop = pop + CNTW'(valid_q[i]);
  end

  // Snapshot reads the registered array, so a same-edge write or clear is not seen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_valid <= 1'b0;
      snap_op    <= OP_OR;
      snap_count <= '0;
      snap_data  <= '0;
    end else begin
      snap_valid <= start;
      if (start) begin
        snap_op    <= op;
        snap_count <= pop;
        snap_data  <= masked;
      end
    end
  end

  assign stage_valid[0] = snap_valid;
  assign stage_op[0]    = snap_op;
  assign stage_count[0] = snap_count;

  for (genvar g = 0; g < LEVELS; g++) begin : lvl
    localparam int PAIRS = SLOTS >> (g + 1);
    logic [2*PAIRS*WIDTH-1:0] operands;
    logic [PAIRS*WIDTH-1:0]   partials;

    if (g == 0) begin : first
      assign operands = snap_data;
    end else begin : chain
      assign operands = lvl[g-1].partials;
    end

    reduce_level #(
      .PAIRS (PAIRS),
      .WIDTH (WIDTH),
      .CNTW  (CNTW)
    ) u_level (
      .clock       (clock),
      .reset       (reset),
      .req_valid   (stage_valid[g]),
      .req_op      (stage_op[g]),
      .req_count   (stage_count[g]),
      .operands    (operands),
      .level_valid (stage_valid[g+1]),
      .level_op    (stage_op[g+1]),
      .level_count (stage_count[g+1]),
      .partials    (partials)
    );
  end

  assign result       = lvl[LEVELS-1].partials;
  assign result_count = stage_count[LEVELS];
  assign result_valid = stage_valid[LEVELS];

endmodule

// File: tb/tb_reduction_array.sv
// Bench for reduction_array: a 4x8 instance under directed and random traffic against an
// array-level reference model, plus a 5x4 instance for non-power-of-two behaviour.
module tb_reduction_array;

  localparam int E   = 4;
  localparam int W   = 8;
  localparam int LV  = 2;
  localparam int E5  = 5;
  localparam int LV5 = 3;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- DUT (4 x 8) ----------------
  logic          clear, enable, remove, start;
  logic [1:0]    index, op;
  logic [W-1:0]  element;
  logic [E*W-1:0] array;
  logic [E-1:0]  valid_mask;
  logic [W-1:0]  result;
  logic [2:0]    result_count;
  logic          result_valid;

  reduction_array #(.ELEMENTS(E), .WIDTH(W)) dut (
    .clock(clock), .reset(reset), .clear(clear), .enable(enable), .remove(remove),
    .index(index), .element(element), .array(array), .valid_mask(valid_mask),
    .start(start), .op(op), .result(result), .result_count(result_count),
    .result_valid(result_valid)
  );

  // ---------------- DUT (5 x 4) ----------------
  logic        clear5, enable5, remove5, start5;
  logic [2:0]  index5;
  logic [1:0]  op5;
  logic [3:0]  element5;
  logic [19:0] array5;
  logic [4:0]  valid_mask5;
  logic [3:0]  result5;
  logic [3:0]  result_count5;
  logic        result_valid5;

  reduction_array #(.ELEMENTS(E5), .WIDTH(4)) dut5 (
    .clock(clock), .reset(reset), .clear(clear5), .enable(enable5), .remove(remove5),
    .index(index5), .element(element5), .array(array5), .valid_mask(valid_mask5),
    .start(start5), .op(op5), .result(result5), .result_count(result_count5),
    .result_valid(result_valid5)
  );

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    int         due;
    logic [7:0] res;
    logic [2:0] cnt;
  } exp_t;

  logic [7:0] mem [E];
  logic [3:0] mvld;
  exp_t       exp_q [$];
  logic [7:0] exp_res;
  logic [2:0] exp_cnt;
  logic [3:0] m5 [E5];
  logic [4:0] v5;
  int         cyc;
  int         checks;
  int         errors;

  function automatic logic [7:0] ref_reduce(input logic [1:0] o);
    logic [7:0] acc;
    acc = (o == 2'd1) ? 8'hff : 8'h00;
    for (int i = 0; i < E; i++) begin
      if (mvld[i]) begin
        case (o)
          2'd0:    acc = acc | mem[i];
          2'd1:    acc = acc & mem[i];
          2'd2:    acc = acc ^ mem[i];
          default: if (mem[i] > acc) acc = mem[i];
        endcase
      end
    end
    return acc;
  endfunction

  function automatic logic [3:0] ref5(input logic [1:0] o);
    logic [3:0] acc;
    acc = (o == 2'd1) ? 4'hf : 4'h0;
    for (int i = 0; i < E5; i++) begin
      if (v5[i]) begin
        case (o)
          2'd0:    acc = acc | m5[i];
          2'd1:    acc = acc & m5[i];
          2'd2:    acc = acc ^ m5[i];
          default: if (m5[i] > acc) acc = m5[i];
        endcase
      end
    end
    return acc;
  endfunction

  function automatic logic [31:0] flat4();
    logic [31:0] f;
    for (int i = 0; i < E; i++) f[i*8 +: 8] = mem[i];
    return f;
  endfunction

  function automatic logic [19:0] flat5();
    logic [19:0] f;
    for (int i = 0; i < E5; i++) f[i*4 +: 4] = m5[i];
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < E; i++) mem[i] = '0;
    mvld = '0;
    for (int i = 0; i < E5; i++) m5[i] = '0;
    v5 = '0;
    exp_q.delete();
    exp_res = '0;
    exp_cnt = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: model follows the sampling edge, outputs are checked on the falling edge.
  task automatic tick();
    exp_t e;
    logic rv;
    @(posedge clock);
    cyc++;
    if (reset) begin
      model_clear();
    end else begin
      if (start) exp_q.push_back('{cyc + LV, ref_reduce(op), 3'($countones(mvld))});
      if (clear) begin
        for (int i = 0; i < E; i++) mem[i] = '0;
        mvld = '0;
      end else if (enable) begin
        if (remove) mvld[index] = 1'b0;
        else begin
          mem[index]  = element;
          mvld[index] = 1'b1;
        end
      end
    end
    @(negedge clock);
    chk("array", array, flat4());
    chk("valid_mask", valid_mask, mvld);
    rv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    if (rv) begin
      e = exp_q.pop_front();
      exp_res = e.res;
      exp_cnt = e.cnt;
    end
    chk("result_valid", result_valid, rv);
    chk("result", result, exp_res);
    chk("result_count", result_count, exp_cnt);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    clear = 0; enable = 0; remove = 0; start = 0; index = 0; op = 0; element = 0;
    clear5 = 0; enable5 = 0; remove5 = 0; start5 = 0; index5 = 0; op5 = 0; element5 = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input int i, input logic [7:0] d);
    enable = 1; remove = 0; index = 2'(i); element = d;
    tick();
    enable = 0;
  endtask

  task automatic rm(input int i);
    enable = 1; remove = 1; index = 2'(i);
    tick();
    enable = 0; remove = 0;
  endtask

  task automatic go(input logic [1:0] o);
    start = 1; op = o;
    tick();
    start = 0;
  endtask

  // Asynchronous reset: outputs must drop before any clock edge arrives.
  task automatic do_reset();
    reset = 1;
    #1;
    model_clear();
    chk("rst_array", array, 0);
    chk("rst_valid_mask", valid_mask, 0);
    chk("rst_result", result, 0);
    chk("rst_result_count", result_count, 0);
    chk("rst_result_valid", result_valid, 0);
    chk("rst_array5", array5, 0);
    chk("rst_result_valid5", result_valid5, 0);
    tick();
    reset = 0;
  endtask

  task automatic wr5(input int i, input logic [3:0] d);
    enable5 = 1; remove5 = 0; index5 = 3'(i); element5 = d;
    tick();
    enable5 = 0;
    if (i < E5) begin
      m5[i] = d;
      v5[i] = 1'b1;
    end
    chk("array5", array5, flat5());
    chk("valid_mask5", valid_mask5, v5);
  endtask

  task automatic launch5(input logic [1:0] o);
    logic [3:0] er;
    logic [3:0] ec;
    er = ref5(o);
    ec = 4'($countones(v5));
    start5 = 1; op5 = o;
    tick();
    start5 = 0;
    chk("lat5_valid", result_valid5, 0);
    for (int k = 1; k <= LV5; k++) begin
      tick();
      chk("lat5_valid", result_valid5, k == LV5);
    end
    chk("result5", result5, er);
    chk("result_count5", result_count5, ec);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    idle_inputs();
    model_clear();
    do_reset();
    idle(1);

    // Clear wins over a simultaneous write.
    wr(0, 8'haa);
    clear = 1; enable = 1; index = 2'd1; element = 8'h55;
    tick();
    clear = 0; enable = 0;

    // Full array, every op back to back.
    wr(0, 8'haa); wr(1, 8'h11); wr(2, 8'h72); wr(3, 8'h88);
    for (int o = 0; o < 4; o++) go(2'(o));
    idle(3);

    // Partial mask: removed data stays on the array.
    rm(0); rm(3);
    go(2'd1); go(2'd2);
    idle(3);

    // Empty mask.
    clear = 1; tick(); clear = 0;
    go(2'd1); go(2'd0);
    idle(3);

    // Same-cycle write is not seen by the launch.
    start = 1; op = 2'd0; enable = 1; index = 2'd0; element = 8'hff;
    tick();
    start = 0; enable = 0;
    idle(3);

    // Clear behind an in-flight request.
    wr(1, 8'h5a);
    go(2'd3);
    clear = 1; tick(); clear = 0;
    idle(3);

    // Reset one cycle after a launch kills it.
    wr(2, 8'h33);
    go(2'd3);
    do_reset();
    idle(4);
    go(2'd0);
    idle(3);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      clear   = ($urandom_range(0, 15) == 0);
      enable  = $urandom_range(0, 1);
      remove  = ($urandom_range(0, 3) == 0);
      index   = 2'($urandom_range(0, 3));
      element = 8'($urandom_range(0, 255));
      start   = $urandom_range(0, 1);
      op      = 2'($urandom_range(0, 3));
      tick();
    end
    idle_inputs();
    idle(4);

    // Non-power-of-two instance: out-of-range indices are ignored.
    for (int i = 0; i < E5; i++) wr5(i, 4'h8);
    for (int i = E5; i < 8; i++) wr5(i, 4'h3);
    launch5(2'd1);
    launch5(2'd3);
    enable5 = 1; remove5 = 1; index5 = 3'd2;
    tick();
    enable5 = 0; remove5 = 0;
    v5[2] = 1'b0;
    wr5(4, 4'hc);
    launch5(2'd2);
    launch5(2'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
